// File: rtl/mw_arith_seq_pkg.sv
// Shared encodings for the multi-word arithmetic sequencer: op codes, ALU control,
// flag bit positions and FSM states.
package mw_arith_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam logic [3:0] ALUC_ADC = 4'b0101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        EX   = 2'b10,
        FIN  = 2'b11
    } state_e;

    // Carry into the least significant word; SUB forms A + ~B + 1.
    function automatic logic first_cin(input logic [1:0] op, input logic cin_init);
        case (op)
            OP_ADD:  first_cin = 1'b0;
            OP_SUB:  first_cin = 1'b1;
            default: first_cin = cin_init;
        endcase
    endfunction

endpackage

// File: rtl/mw_arith_seq.sv
// N-word ADD/SUB/ADC/SBC sequencer driving an external 32-bit ALU, one word per
// two cycles (read, then execute+writeback), least significant word first.
module mw_arith_seq
    import mw_arith_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic              Cin_init,
    input  logic [CNT_W-1:0]  NumWords,
    input  logic [ADDR_W-1:0] BaseA,
    input  logic [ADDR_W-1:0] BaseB,
    input  logic [ADDR_W-1:0] BaseD,
    output logic [ADDR_W-1:0] Rd_Addr_A,
    output logic [ADDR_W-1:0] Rd_Addr_B,
    input  logic [31:0]       Rd_Data_A,
    input  logic [31:0]       Rd_Data_B,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [31:0]       Wr_Data,
    output logic [31:0]       ALU_SrcA,
    output logic [31:0]       ALU_SrcB,
    output logic [3:0]        ALU_Control,
    output logic              ALU_Cin,
    input  logic [31:0]       ALU_Result,
    input  logic [3:0]        ALU_Flags,
    output logic              Busy,
    output logic              Done,
    output logic [3:0]        Flags_out,
    output state_e            state_dbg
);

    state_e            state, state_next;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  num_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_d_q;
    logic [1:0]        op_q;
    logic              carry_q;
    logic              zacc_q;
    logic [3:0]        flag_pend_q;
    logic              last_word;
    logic [3:0]        final_flags;

    assign last_word = (idx == num_q - CNT_W'(1));
    assign state_dbg = state;
    assign Busy      = (state != IDLE);

    always_comb begin
        final_flags         = '0;
        final_flags[FLAG_N] = ALU_Flags[FLAG_N];
        final_flags[FLAG_Z] = zacc_q & ALU_Flags[FLAG_Z];
        final_flags[FLAG_C] = ALU_Flags[FLAG_C];
        final_flags[FLAG_V] = ALU_Flags[FLAG_V];
    end

    always_comb begin
        state_next  = state;
        Rd_Addr_A   = '0;
        Rd_Addr_B   = '0;
        Wr_En       = 1'b0;
        Wr_Addr     = '0;
        Wr_Data     = '0;
        ALU_SrcA    = '0;
        ALU_SrcB    = '0;
        ALU_Control = '0;
        ALU_Cin     = 1'b0;
        Done        = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = (NumWords == '0) ? FIN : RD;
            end
            RD: begin
                Rd_Addr_A  = base_a_q + ADDR_W'(idx);
                Rd_Addr_B  = base_b_q + ADDR_W'(idx);
                state_next = EX;
            end
            EX: begin
                // Subtraction is A + ~B + carry; op bit 0 marks SUB/SBC.
                ALU_SrcA    = Rd_Data_A;
                ALU_SrcB    = op_q[0] ? ~Rd_Data_B : Rd_Data_B;
                ALU_Control = ALUC_ADC;
                ALU_Cin     = carry_q;
                Wr_En       = 1'b1;
                Wr_Addr     = base_d_q + ADDR_W'(idx);
                Wr_Data     = ALU_Result;
                state_next  = last_word ? FIN : RD;
            end
            FIN: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            idx         <= '0;
            num_q       <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_d_q    <= '0;
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            flag_pend_q <= '0;
            Flags_out   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        num_q    <= NumWords;
                        base_a_q <= BaseA;
                        base_b_q <= BaseB;
                        base_d_q <= BaseD;
                        op_q     <= Op;
                        idx      <= '0;
                        zacc_q   <= 1'b1;
                        // The carry register holds the first-word carry-in from the start.
                        carry_q  <= first_cin(Op, Cin_init);
                    end
                end
                EX: begin
                    carry_q <= ALU_Flags[FLAG_C];
                    zacc_q  <= zacc_q & ALU_Flags[FLAG_Z];
                    if (last_word) flag_pend_q <= final_flags;
                    else           idx         <= idx + CNT_W'(1);
                end
                FIN: begin
                    if (num_q != '0) Flags_out <= flag_pend_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mw_arith_seq.sv
// Bench for mw_arith_seq: behavioural ALU and scratch memory beside the DUT,
// table vectors plus random ops, write scoreboard, reset-abort sequence.
module tb_mw_arith_seq;
    import mw_arith_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic        Cin_init = 1'b0;
    logic [3:0]  NumWords = '0;
    logic [7:0]  BaseA = '0, BaseB = '0, BaseD = '0;
    logic [7:0]  Rd_Addr_A, Rd_Addr_B;
    logic [31:0] Rd_Data_A, Rd_Data_B;
    logic        Wr_En;
    logic [7:0]  Wr_Addr;
    logic [31:0] Wr_Data;
    logic [31:0] ALU_SrcA, ALU_SrcB;
    logic [3:0]  ALU_Control;
    logic        ALU_Cin;
    logic [31:0] ALU_Result;
    logic [3:0]  ALU_Flags;
    logic        Busy, Done;
    logic [3:0]  Flags_out;
    state_e      state_dbg;

    mw_arith_seq #(.ADDR_W(8), .CNT_W(4)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .Op(Op), .Cin_init(Cin_init),
        .NumWords(NumWords), .BaseA(BaseA), .BaseB(BaseB), .BaseD(BaseD),
        .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B), .Rd_Data_A(Rd_Data_A), .Rd_Data_B(Rd_Data_B),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Control(ALU_Control), .ALU_Cin(ALU_Cin),
        .ALU_Result(ALU_Result), .ALU_Flags(ALU_Flags),
        .Busy(Busy), .Done(Done), .Flags_out(Flags_out), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: only the add-with-carry control produces a real sum.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum    = {1'b0, ALU_SrcA} + {1'b0, ALU_SrcB} + {32'd0, ALU_Cin};
        ALU_Result = (ALU_Control == 4'b0101) ? alu_sum[31:0] : 32'hDEADBEEF;
        ALU_Flags  = {ALU_Result[31], ALU_Result == 32'd0, alu_sum[32],
                      (ALU_SrcA[31] == ALU_SrcB[31]) && (ALU_Result[31] != ALU_SrcA[31])};
    end

    // Scratch memory: registered reads, one write port shared by the loader and the DUT.
    logic [31:0] mem [256];
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    always @(posedge CLK) begin
        Rd_Data_A <= mem[Rd_Addr_A];
        Rd_Data_B <= mem[Rd_Addr_B];
        if (load_en)    mem[load_addr] <= load_data;
        else if (Wr_En) mem[Wr_Addr]   <= Wr_Data;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [39:0] exp_q[$];
    logic [3:0]  last_flags = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (RESETn && Wr_En) begin
            if (exp_q.size() == 0) chk("unexpected_write", {Wr_Addr, Wr_Data}, '0);
            else chk("write", {88'd0, Wr_Addr, Wr_Data}, {88'd0, exp_q.pop_front()});
        end
    end

    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        @(negedge CLK);
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(negedge CLK);
        load_en = 1'b0;
    endtask

    function automatic void ref_calc(input logic [1:0] op, input logic cin, input int n,
                                     input logic [127:0] a, input logic [127:0] b,
                                     output logic [127:0] d, output logic [3:0] f);
        logic [128:0] mask, am, bm, sum;
        logic         c0;
        mask = (129'd1 << (32 * n)) - 129'd1;
        am   = {1'b0, a} & mask;
        bm   = op[0] ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
        c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
        sum  = am + bm + {128'd0, c0};
        d    = sum[127:0] & mask[127:0];
        f[3] = d[32*n-1];
        f[2] = (d == 128'd0);
        f[1] = sum[32*n];
        f[0] = (am[32*n-1] == bm[32*n-1]) && (d[32*n-1] != am[32*n-1]);
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic cin, input int n,
                          input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd,
                          input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] exp_d, input logic [3:0] exp_f, input bit hold);
        int   cycles;
        logic busy1;
        logic [3:0] want_f;
        for (int i = 0; i < n; i++) begin
            load_word(ba + 8'(i), a[32*i +: 32]);
            load_word(bb + 8'(i), b[32*i +: 32]);
        end
        @(negedge CLK);
        for (int i = 0; i < n; i++) exp_q.push_back({bd + 8'(i), exp_d[32*i +: 32]});
        Start = 1'b1; Op = op; Cin_init = cin; NumWords = 4'(n);
        BaseA = ba; BaseB = bb; BaseD = bd;
        cycles = 0;
        busy1  = 1'b0;
        do begin
            @(negedge CLK);
            cycles++;
            if (cycles == 1) busy1 = Busy;
            if (!hold || Done) Start = 1'b0;
            else begin
                // Junk on the request inputs while busy must not disturb the run.
                Op = 2'($urandom_range(0, 3)); Cin_init = ~Cin_init;
                NumWords = 4'($urandom_range(1, 15));
                BaseA = 8'($urandom); BaseB = 8'($urandom); BaseD = 8'($urandom);
            end
        end while (!Done && cycles < 100);
        Start = 1'b0;
        chk({name, "_latency"}, 128'(cycles), 128'(2 * n + 1));
        chk({name, "_busy"}, {127'd0, busy1}, 128'd1);
        chk({name, "_idle_outs"}, {Wr_En, ALU_Control, ALU_Cin, ALU_SrcA, ALU_SrcB}, '0);
        want_f = (n == 0) ? last_flags : exp_f;
        @(negedge CLK);
        chk({name, "_flags"}, {124'd0, Flags_out}, {124'd0, want_f});
        chk({name, "_done_busy_low"}, {126'd0, Done, Busy}, '0);
        chk({name, "_writes_left"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        last_flags = want_f;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic         cin;
        int           n;
        logic [7:0]   ba, bb, bd;
        logic [127:0] a, b, d;
        logic [3:0]   f;
        bit           hold;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{OP_ADD, 1'b0, 2, 8'h10, 8'h20, 8'h30, 128'h00000001_FFFFFFFF, 128'h00000000_00000001, 128'h00000002_00000000, 4'b0000, 1'b0};
        vecs[1]  = '{OP_SUB, 1'b0, 2, 8'h10, 8'h20, 8'h30, 128'h12345678_9ABCDEF0, 128'h12345678_9ABCDEF0, 128'h0, 4'b0110, 1'b1};
        vecs[2]  = '{OP_ADD, 1'b0, 0, 8'h10, 8'h20, 8'h30, 128'h0, 128'h0, 128'h0, 4'b0000, 1'b0};
        vecs[3]  = '{OP_ADD, 1'b0, 2, 8'h10, 8'h20, 8'h30, 128'h7FFFFFFF_FFFFFFFF, 128'h1, 128'h80000000_00000000, 4'b1001, 1'b0};
        vecs[4]  = '{OP_SBC, 1'b0, 1, 8'h11, 8'h21, 8'h31, 128'h5, 128'h3, 128'h1, 4'b0010, 1'b0};
        vecs[5]  = '{OP_SBC, 1'b1, 1, 8'h11, 8'h21, 8'h31, 128'h5, 128'h3, 128'h2, 4'b0010, 1'b0};
        vecs[6]  = '{OP_ADC, 1'b1, 1, 8'h12, 8'h22, 8'h32, 128'hFFFFFFFF, 128'h0, 128'h0, 4'b0110, 1'b0};
        vecs[7]  = '{OP_SUB, 1'b0, 1, 8'h13, 8'h23, 8'h33, 128'h0, 128'h1, 128'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[8]  = '{OP_SUB, 1'b0, 1, 8'h13, 8'h23, 8'h33, 128'h80000000, 128'h1, 128'h7FFFFFFF, 4'b0011, 1'b0};
        vecs[9]  = '{OP_ADD, 1'b0, 2, 8'hFF, 8'h7F, 8'hFE, 128'h00000003_00000004, 128'h00000010_00000020, 128'h00000013_00000024, 4'b0000, 1'b0};
        vecs[10] = '{OP_ADD, 1'b1, 1, 8'h14, 8'h24, 8'h34, 128'h1, 128'h1, 128'h2, 4'b0000, 1'b0};
        vecs[11] = '{OP_SUB, 1'b0, 2, 8'h40, 8'h50, 8'h40, 128'h5, 128'h7, 128'hFFFFFFFF_FFFFFFFE, 4'b1000, 1'b0};

        repeat (3) @(negedge CLK);
        chk("reset_outs_a", {Rd_Addr_A, Rd_Addr_B, Wr_En, Wr_Addr, Wr_Data, ALU_SrcA, ALU_SrcB}, '0);
        chk("reset_outs_b", {ALU_Control, ALU_Cin, Busy, Done, Flags_out, state_dbg}, '0);
        RESETn = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 12; k++)
            run_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].cin, vecs[k].n,
                   vecs[k].ba, vecs[k].bb, vecs[k].bd, vecs[k].a, vecs[k].b,
                   vecs[k].d, vecs[k].f, vecs[k].hold);

        // Reset in the second EX of a 3-word ADD: only word 0 may be written.
        begin
            logic done_seen;
            load_word(8'h60, 32'h3);  load_word(8'h61, 32'h2);  load_word(8'h62, 32'h1);
            load_word(8'h70, 32'h30); load_word(8'h71, 32'h20); load_word(8'h72, 32'h10);
            @(negedge CLK);
            exp_q.push_back({8'h90, 32'h33});
            Start = 1'b1; Op = OP_ADD; Cin_init = 1'b0; NumWords = 4'd3;
            BaseA = 8'h60; BaseB = 8'h70; BaseD = 8'h90;
            @(negedge CLK); Start = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            @(posedge CLK); #1;
            chk("abort_in_ex", {126'd0, state_dbg}, {126'd0, EX});
            RESETn = 1'b0;
            #1;
            chk("abort_outs", {Busy, Done, Wr_En, Flags_out}, '0);
            done_seen = 1'b0;
            repeat (2) begin @(negedge CLK); done_seen |= Done; end
            RESETn = 1'b1;
            repeat (8) begin @(negedge CLK); done_seen |= Done; end
            chk("abort_no_done", {127'd0, done_seen}, '0);
            chk("abort_writes_left", 128'(exp_q.size()), 128'd0);
            chk("abort_flags", {124'd0, Flags_out}, '0);
            exp_q.delete();
            last_flags = '0;
            run_op("after_abort", OP_ADD, 1'b0, 1, 8'h60, 8'h70, 8'h90,
                   128'h3, 128'h30, 128'h33, 4'b0000, 1'b0);
        end

        for (int k = 0; k < 8; k++) begin
            logic [1:0]   op;
            logic         cin;
            int           n;
            logic [127:0] a, b, d;
            logic [3:0]   f;
            op  = 2'($urandom_range(0, 3));
            cin = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 4);
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom, $urandom};
            ref_calc(op, cin, n, a, b, d, f);
            run_op($sformatf("rand%0d", k), op, cin, n,
                   8'($urandom_range(0, 15)), 8'h40 + 8'($urandom_range(0, 15)),
                   8'h80 + 8'($urandom_range(0, 15)), a, b, d, f, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mw_arith_seq.md
Name: mw_arith_seq

Overview:
- Multi-word arithmetic sequencer that drives the shared 32-bit ALU through its carry-in port.
- Performs N-word (N x 32-bit) ADD/SUB/ADC/SBC on operands held in a word-addressed scratch memory, one word per pass, LSW first.
- Sits beside the ALU in the datapath; while Busy is high it owns the ALU operand/control/C_in inputs and drives the write port of the scratch memory.

Parameters:
- ADDR_W, 8, scratch memory word-address width; all address arithmetic is modulo 2^ADDR_W.
- CNT_W, 4, width of NumWords; maximum operand length is 2^CNT_W-1 words.

Ports:
- CLK  in  1  rising-edge clock.
- RESETn  in  1  reset; asynchronous, active-low.
- Start  in  1  request pulse; sampled only in IDLE.
- Op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC; latched at Start.
- Cin_init  in  1  carry-in for the first word when Op is ADC or SBC; latched at Start.
- NumWords  in  CNT_W  operand length in words; latched at Start.
- BaseA, BaseB, BaseD  in  ADDR_W each  LSW addresses of operand A, operand B and result D; latched at Start.
- Rd_Addr_A, Rd_Addr_B  out  ADDR_W each  read addresses; data returns one cycle later.
- Rd_Data_A, Rd_Data_B  in  32 each  read data.
- Wr_En  out  1  result write strobe.
- Wr_Addr  out  ADDR_W  result write address.
- Wr_Data  out  32  result word.
- ALU_SrcA, ALU_SrcB  out  32 each  to ALU Src_A/Src_B.
- ALU_Control  out  4  to ALU ALUControl.
- ALU_Cin  out  1  to ALU C_in.
- ALU_Result  in  32  from ALU.
- ALU_Flags  in  4  from ALU, {N,Z,C,V}.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle completion pulse.
- Flags_out  out  4  {N,Z,C,V} of the completed multi-word result; held until the next completion.

Behaviour:
- Reset values: all outputs 0. State = IDLE, word index 0, carry register 0, Z accumulator 1.
- FSM states and transitions:
  - IDLE: if Start=1, latch all operands. If NumWords=0, go to FIN. Otherwise go to RD with index i=0.
  - RD: drive Rd_Addr_A=BaseA+i and Rd_Addr_B=BaseB+i; go to EX.
  - EX: drive ALU_SrcA=Rd_Data_A, ALU_Control=4'b0101 (ADC). ALU_Control is always 0101; subtraction is formed by inversion.
    - ALU_SrcB: Rd_Data_B for ADD/ADC; ~Rd_Data_B for SUB/SBC.
    - ALU_Cin for i=0: ADD=0, SUB=1, ADC/SBC=Cin_init. For i>0: the registered carry.
    - Same cycle: Wr_En=1, Wr_Addr=BaseD+i, Wr_Data=ALU_Result.
    - Register carry<=ALU_Flags[1] and Zacc<=Zacc&ALU_Flags[2].
    - If i==NumWords-1, go to FIN and capture N=ALU_Flags[3], V=ALU_Flags[0], C=ALU_Flags[1], Z=Zacc&ALU_Flags[2]. Otherwise i<=i+1 and go to RD.
  - FIN: Done=1 for one cycle; update Flags_out (unchanged if NumWords was 0); go to IDLE.
- Outputs outside RD/EX:
  - Wr_En=0 outside EX.
  - ALU_* outputs are 0 outside EX; external muxing selects this block only while Busy.
- Latency: Start to Done = 2*NumWords+1 cycles; throughput is 2 cycles per word.
- Carry convention is ARM-style: for SUB/SBC, C=1 means no borrow.
- Start while Busy is ignored (no queueing). Start and Done may coincide with no conflict, because Start is only sampled in IDLE.
- Address wrap: BaseX+i wraps modulo 2^ADDR_W with no error indication.
- Overlapping D with A/B is legal: word i is read before it is written, and word i is never reread.
- Reset mid-operation: immediate abort; no further Wr_En; Flags_out returns to 0.

Decomposition:
- Shared package holds:
  - Op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBC.
  - ALU control constant ALUC_ADC=4'b0101.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - State encodings IDLE/RD/EX/FIN.
- Single module; no sub-module. The ALU stays external and is instantiated beside this block in the datapath.

Test Plan:
- ADD, N=2, A={hi 0x00000001, lo 0xFFFFFFFF}, B={0x00000000, 0x00000001} -> D={0x00000002, 0x00000000}; Flags {0,0,0,0}; Done exactly 5 cycles after Start.
- SUB, N=2, A=B=0x12345678_9ABCDEF0 -> D=0; Flags {N0,Z1,C1,V0}; 2 writes at BaseD, BaseD+1.
- ADD, N=2, A=0x7FFFFFFF_FFFFFFFF, B=1 -> D=0x80000000_00000000; Flags {1,0,0,1}.
- SBC, N=1, Cin_init=0, A=5, B=3 -> D=1; C=1. With Cin_init=1 -> D=2.
- NumWords=0 -> Done 1 cycle after Start, no Wr_En, Flags_out unchanged. Start asserted while Busy -> ignored.
- RESETn low during the second EX of an N=3 ADD -> Busy=0, Done never pulses, no writes after reset, Flags_out=0. A new Start then completes normally.
